// File: rtl/team_06_wb_sram_responder.sv
// -----------------------------------------------------------------------------
// team_06_wb_sram_responder
//
// Wishbone classic subordinate backed by a small on-chip word memory of
// 2^DEPTH_LOG2 x 32 bits. A request is accepted in IDLE, optionally held for
// WAIT_STATES cycles, then acknowledged for exactly one cycle. Writes commit
// with byte-lane granularity in the ACK cycle. Read data is registered so it
// is valid in the ACK cycle and zero at all other times. Accesses outside the
// address window still ack, but writes are dropped, reads return zero and
// oor_err pulses together with wack.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset (also clears the memory)
//   wadr     byte address from manager; bits [1:0] are ignored
//   wdato    write data from manager
//   wsel     byte-lane enables, bit i covers bits [8i+7:8i]
//   wwe      1 = write, 0 = read
//   wstb     strobe
//   wcyc     bus cycle valid
//   wdati    read data to manager (zero outside the ACK cycle)
//   wack     single-cycle acknowledge
//   oor_err  pulse coincident with wack for an out-of-window access
// -----------------------------------------------------------------------------
module team_06_wb_sram_responder #(
  parameter int          DEPTH_LOG2  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wadr,
  input  logic [31:0] wdato,
  input  logic [3:0]  wsel,
  input  logic        wwe,
  input  logic        wstb,
  input  logic        wcyc,
  output logic [31:0] wdati,
  output logic        wack,
  output logic        oor_err
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam int         AW    = DEPTH_LOG2;
  localparam logic [3:0] WS4   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic          hit_q, hit_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH];

  logic          req;
  logic          req_hit;
  logic [AW-1:0] req_idx;
  logic          commit;
  logic [31:0]   wmask;
  logic          unused_adr_bits;

  assign req     = wcyc & wstb;
  assign req_hit = (wadr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign req_idx = wadr[AW+1:2];

  // The byte offset within a word plays no part in decode.
  assign unused_adr_bits = ^wadr[1:0];

  // Expand the latched byte enables into a 32-bit lane mask.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[8*gi +: 8] = {8{sel_q[gi]}};
    end
  endgenerate

  // Next-state logic. Request fields are captured only in IDLE, so the bus
  // may change freely while a transaction is pending.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    hit_d   = hit_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = req_idx;
          dat_d   = wdato;
          sel_d   = wsel;
          we_d    = wwe;
          hit_d   = req_hit;
          cnt_d   = WS4;
          state_d = (WS4 != 4'd0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        if (!req) begin
          // Manager withdrew the request: abandon it without ack or write.
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Read data is fetched on the edge entering ACK, using the fields that are
  // being latched (IDLE with no wait states) or already held (WAIT). Every
  // other edge loads zero, keeping wdati quiet outside the ACK cycle.
  always_comb begin
    rdata_d = '0;
    if (state_d == S_ACK && hit_d && !we_d) begin
      rdata_d = mem_q[idx_d];
    end
  end

  assign commit = (state_q == S_ACK) && we_q && hit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory contents are cleared by reset, so the array is built from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[idx_q] <= (mem_q[idx_q] & ~wmask) | (dat_q & wmask);
    end
  end

  assign wack    = (state_q == S_ACK);
  assign oor_err = (state_q == S_ACK) && !hit_q;
  assign wdati   = rdata_q;

endmodule

// File: tb/tb_team_06_wb_sram_responder.sv
// Bench for team_06_wb_sram_responder. Two instances are exercised: one with
// one wait state (default) and one with three. Stimulus pushes the expected
// response (data, out-of-range flag, ack cycle) into a per-instance queue; a
// negedge monitor pops and compares whenever wack is seen and otherwise
// checks that the outputs are quiet.
module tb_team_06_wb_sram_responder;

  localparam logic [31:0] BASE = 32'h3300_0000;

  typedef struct {
    logic [31:0] data;
    logic        oor;
    int          at;
    logic [31:0] adr;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst     [2];
  logic [31:0] wadr    [2];
  logic [31:0] wdato   [2];
  logic [3:0]  wsel    [2];
  logic        wwe     [2];
  logic        wstb    [2];
  logic        wcyc    [2];
  logic [31:0] wdati   [2];
  logic        wack    [2];
  logic        oor_err [2];

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  team_06_wb_sram_responder #(.DEPTH_LOG2(8), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .rst(rst[0]), .wadr(wadr[0]), .wdato(wdato[0]), .wsel(wsel[0]),
    .wwe(wwe[0]), .wstb(wstb[0]), .wcyc(wcyc[0]), .wdati(wdati[0]),
    .wack(wack[0]), .oor_err(oor_err[0])
  );

  team_06_wb_sram_responder #(.DEPTH_LOG2(8), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .rst(rst[1]), .wadr(wadr[1]), .wdato(wdato[1]), .wsel(wsel[1]),
    .wwe(wwe[1]), .wstb(wstb[1]), .wcyc(wcyc[1]), .wdati(wdati[1]),
    .wack(wack[1]), .oor_err(oor_err[1])
  );

  function automatic int ws(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit in_window(logic [31:0] a);
    return (a >> 10) == (BASE >> 10);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic mon(int d);
    exp_t e;
    bit   empty;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (wack[d] === 1'b1) begin
      if (empty) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack dut%0d: got wack=1 expected 0 (cycle %0d)", d, cyc);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        $display("dut%0d %s adr=%h wdati=%h oor=%0b cycle=%0d", d, e.we ? "WR" : "RD",
                 e.adr, wdati[d], oor_err[d], cyc);
        check($sformatf("ack_data dut%0d", d), wdati[d], e.data);
        check($sformatf("ack_oor dut%0d", d), 32'(oor_err[d]), 32'(e.oor));
        check($sformatf("ack_cycle dut%0d", d), 32'(cyc), 32'(e.at));
      end
    end else begin
      check($sformatf("idle_wack dut%0d", d), 32'(wack[d]), 32'h0);
      check($sformatf("idle_wdati dut%0d", d), wdati[d], 32'h0);
      check($sformatf("idle_oor dut%0d", d), 32'(oor_err[d]), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // One complete bus access. Called right after a rising edge (+1) with the
  // DUT in IDLE. With keep=1 the strobe is left high so the next call forms
  // a back-to-back transaction.
  task automatic access(int d, bit we, logic [31:0] adr, logic [31:0] dat,
                        logic [3:0] sel, bit keep);
    exp_t        e;
    bit          hit;
    int          idx;
    bit          got;
    logic [31:0] w;
    hit   = in_window(adr);
    idx   = int'((adr >> 2) & 32'hFF);
    e.at  = cyc + 1 + ws(d);
    e.oor = !hit;
    e.adr = adr;
    e.we  = we;
    e.data = (!we && hit) ? model[d][idx] : 32'h0;
    if (we && hit) begin
      w = model[d][idx];
      for (int b = 0; b < 4; b++) begin
        if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
      end
      model[d][idx] = w;
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    wadr[d]  = adr;
    wdato[d] = dat;
    wsel[d]  = sel;
    wwe[d]   = we;
    wstb[d]  = 1'b1;
    wcyc[d]  = 1'b1;
    @(posedge clk); #1;
    // Request fields must be ignored once accepted.
    wadr[d]  = $urandom;
    wdato[d] = $urandom;
    wsel[d]  = 4'($urandom);
    wwe[d]   = 1'($urandom);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (wack[d] === 1'b1);
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout dut%0d: got no wack expected one for adr %h", d, adr);
    end
    @(posedge clk); #1;
    if (!keep) begin
      wstb[d] = 1'b0;
      wcyc[d] = 1'b0;
    end
  endtask

  task automatic wait_q_empty();
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
    check("queue_drained", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we;
    bit          keep;
    int          r;
    logic [31:0] adr;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; wadr[d] = '0; wdato[d] = '0; wsel[d] = '0;
      wwe[d] = 1'b0; wstb[d] = 1'b0; wcyc[d] = 1'b0;
      for (int i = 0; i < 256; i++) model[d][i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_wack", 32'(wack[0]), 32'h0);
    check("reset_wdati", wdati[0], 32'h0);
    check("reset_oor", 32'(oor_err[0]), 32'h0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk); #1;

    // Directed: read after reset, full/partial writes, window edges, misses.
    access(0, 0, BASE + 32'h10, 32'h0, 4'hF, 0);
    access(0, 1, BASE + 32'h04, 32'hDEADBEEF, 4'hF, 0);
    access(0, 0, BASE + 32'h04, 32'h0, 4'hF, 0);
    access(0, 1, BASE + 32'h04, 32'h000000AA, 4'h1, 0);
    access(0, 0, BASE + 32'h04, 32'h0, 4'h0, 0);
    access(0, 1, BASE + 32'h04, 32'hFFFFFFFF, 4'h0, 0);
    access(0, 0, BASE + 32'h04, 32'h0, 4'hF, 0);
    access(0, 1, BASE + 32'h3FC, 32'h11112222, 4'hF, 0);
    access(0, 1, BASE + 32'h000, 32'h33334444, 4'hF, 0);
    access(0, 0, BASE + 32'h3FC, 32'h0, 4'hF, 0);
    access(0, 0, BASE + 32'h000, 32'h0, 4'hF, 0);
    access(0, 1, BASE + 32'h400, 32'h55555555, 4'hF, 0);
    access(0, 0, BASE + 32'h400, 32'h0, 4'hF, 0);
    access(0, 0, BASE + 32'h000, 32'h0, 4'hF, 0);
    access(0, 0, BASE + 32'h006, 32'h0, 4'hF, 0);

    // Back-to-back reads on both instances.
    for (int d = 0; d < 2; d++) begin
      access(d, 1, BASE + 32'h40, 32'hA0A0A0A0 + d, 4'hF, 0);
      access(d, 1, BASE + 32'h44, 32'hB1B1B1B1 + d, 4'hF, 0);
      access(d, 1, BASE + 32'h48, 32'hC2C2C2C2 + d, 4'hF, 0);
      access(d, 0, BASE + 32'h40, 32'h0, 4'hF, 1);
      access(d, 0, BASE + 32'h44, 32'h0, 4'hF, 1);
      access(d, 0, BASE + 32'h48, 32'h0, 4'hF, 0);
    end

    // Abort on the three-wait-state instance: strobe dropped mid-wait.
    wadr[1] = BASE + 32'h40; wdato[1] = 32'h12345678; wsel[1] = 4'hF;
    wwe[1] = 1'b1; wstb[1] = 1'b1; wcyc[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wstb[1] = 1'b0; wcyc[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    access(1, 0, BASE + 32'h40, 32'h0, 4'hF, 0);
    access(1, 1, BASE + 32'h4C, 32'h0BADF00D, 4'hF, 0);
    access(1, 0, BASE + 32'h4C, 32'h0, 4'hF, 0);

    // Reset during the wait state of a write on the one-wait-state instance.
    wadr[0] = BASE + 32'h20; wdato[0] = 32'h87654321; wsel[0] = 4'hF;
    wwe[0] = 1'b1; wstb[0] = 1'b1; wcyc[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    wstb[0] = 1'b0; wcyc[0] = 1'b0;
    #1;
    check("midrst_wack", 32'(wack[0]), 32'h0);
    check("midrst_wdati", wdati[0], 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    for (int i = 0; i < 256; i++) model[0][i] = 32'h0;
    @(posedge clk); #1;
    access(0, 0, BASE + 32'h20, 32'h0, 4'hF, 0);
    access(0, 0, BASE + 32'h04, 32'h0, 4'hF, 0);

    // Randomized traffic against the reference model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ((d == 0) ? 150 : 40); i++) begin
        we = 1'($urandom);
        r  = int'($urandom_range(0, 9));
        if (r == 0)      adr = BASE + 32'h400 + ($urandom_range(0, 63) << 2);
        else if (r == 1) adr = 32'h8000_0000 | $urandom;
        else if (r == 2) adr = BASE + 32'h3FC;
        else             adr = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
        keep = (i != ((d == 0) ? 149 : 39)) && ($urandom_range(0, 1) == 1);
        access(d, we, adr, $urandom, 4'($urandom), keep);
      end
    end

    wait_q_empty();
    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
